// File: rtl/colparity_seq.sv
// Slice-wise column-parity sequencer: streams (previous, current) slice pairs from
// the slice memory into colParity and writes each result slice back in place.
module colparity_seq #(
  parameter int unsigned SLICE_W    = 25,
  parameter int unsigned NUM_SLICES = 64,
  parameter int unsigned IDX_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [IDX_W-1:0]   rd_addr,
  input  logic [SLICE_W-1:0] rd_data,
  output logic [SLICE_W-1:0] cp_prev,
  output logic [SLICE_W-1:0] cp_cur,
  input  logic [SLICE_W-1:0] cp_out,
  output logic               wr_en,
  output logic [IDX_W-1:0]   wr_addr,
  output logic [SLICE_W-1:0] wr_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               rd_vld_q;
  logic               first_q;
  logic [IDX_W-1:0]   rd_idx_q;
  logic [SLICE_W-1:0] prev_q;

  // NOTE: every output and next-state signal gets a default before the case,
  // so no path through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_PRIME;
      end
      // The last slice is read first so slice 0 has its wrap-around neighbour.
      S_PRIME: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = LAST_IDX;
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = cnt_q;
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        busy    = 1'b1;
        state_d = S_FIN;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rd_vld_q <= 1'b0;
      first_q  <= 1'b0;
      rd_idx_q <= '0;
      prev_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_vld_q <= rd_en;
      first_q  <= (state_q == S_PRIME);
      rd_idx_q <= rd_addr;
      if (rd_vld_q) prev_q <= rd_data;
    end
  end

  // The primed slice only seeds prev_q; every later returned slice produces a write.
  assign wr_en   = rd_vld_q & ~first_q;
  assign wr_addr = rd_idx_q;
  assign wr_data = cp_out;
  assign cp_prev = prev_q;
  assign cp_cur  = rd_data;

endmodule

// File: tb/tb_colparity_seq.sv
// Bench for colparity_seq: behavioural slice memory, colParity stand-in and a
// whole-state theta column-parity golden model with cycle-accurate trace checks.
module tb_colparity_seq;

  localparam int SW = 25;
  localparam int NS = 64;
  localparam int IW = 6;

  typedef struct {
    int          cyc;
    int          addr;
    logic [SW-1:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, rd_en, wr_en;
  logic [IW-1:0] rd_addr, wr_addr;
  logic [SW-1:0] rd_data = '0;
  logic [SW-1:0] cp_prev, cp_cur, cp_out, wr_data;

  logic [SW-1:0] mem     [NS];
  logic [SW-1:0] img     [NS];
  logic [SW-1:0] exp_st  [NS];
  logic          load = 1'b0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  ev_t wr_q[$];
  ev_t rd_q[$];
  int  done_q[$];
  int  busy_q[$];

  colparity_seq #(.SLICE_W(SW), .NUM_SLICES(NS), .IDX_W(IW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .cp_prev (cp_prev),
    .cp_cur  (cp_cur),
    .cp_out  (cp_out),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous slice memory with one-cycle read latency.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NS; i++) mem[i] <= img[i];
    end else begin
      if (rd_en) rd_data <= mem[rd_addr];
      if (wr_en) mem[wr_addr] <= wr_data;
    end
  end

  // colParity stand-in: bit (x,y) of a slice is bit 5*y+x; result is
  // A ^ C[x-1](current slice) ^ C[x+1](previous slice).
  function automatic logic [SW-1:0] col_parity(input logic [SW-1:0] prev, input logic [SW-1:0] cur);
    logic [4:0] cp, cc;
    logic [SW-1:0] r;
    for (int x = 0; x < 5; x++) begin
      cp[x] = 1'b0;
      cc[x] = 1'b0;
      for (int y = 0; y < 5; y++) begin
        cp[x] = cp[x] ^ prev[5*y+x];
        cc[x] = cc[x] ^ cur[5*y+x];
      end
    end
    r = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[5*y+x] = cur[5*y+x] ^ cc[(x+4)%5] ^ cp[(x+1)%5];
    return r;
  endfunction

  assign cp_out = col_parity(cp_prev, cp_cur);

  always @(negedge clk) begin
    if (wr_en) wr_q.push_back('{cyc: cyc, addr: int'(wr_addr), data: wr_data});
    if (rd_en) rd_q.push_back('{cyc: cyc, addr: int'(rd_addr), data: '0});
    if (done)  done_q.push_back(cyc);
    if (busy)  busy_q.push_back(cyc);
  end

  task automatic clear_logs();
    wr_q.delete();
    rd_q.delete();
    done_q.delete();
    busy_q.delete();
  endtask

  // Whole-state golden: column parities C[x][z] over the full 5x5x64 state,
  // then A'[x][y][z] = A ^ C[x-1][z] ^ C[x+1][z-1 mod NS].
  task automatic compute_expected();
    logic c [5][NS];
    for (int z = 0; z < NS; z++)
      for (int x = 0; x < 5; x++) begin
        c[x][z] = 1'b0;
        for (int y = 0; y < 5; y++) c[x][z] = c[x][z] ^ mem[z][5*y+x];
      end
    for (int z = 0; z < NS; z++)
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          exp_st[z][5*y+x] = mem[z][5*y+x] ^ c[(x+4)%5][z] ^ c[(x+1)%5][(z+NS-1)%NS];
  endtask

  task automatic load_state(input int mode);
    for (int i = 0; i < NS; i++) begin
      if (mode == 0)      img[i] = '0;
      else if (mode == 1) img[i] = (i == NS-1) ? SW'(1) : '0;
      else                img[i] = SW'($urandom);
    end
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Launches one pass and waits for done; extra start pulses at relative cycles e1/e2.
  task automatic do_pass(input int e1, input int e2, output int t0);
    bit got;
    @(negedge clk);
    clear_logs();
    compute_expected();
    t0 = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      if (done) got = 1'b1;
      else begin
        @(negedge clk);
        start = ((cyc - t0) == e1) || ((cyc - t0) == e2);
      end
    end
    start = 1'b0;
    #1;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done not seen within 200 cycles of start at cycle %0d", t0);
    end
  endtask

  task automatic check_pass(input int t0, input string tag);
    bool_check: begin
      int n;
      bit order_ok;
      checks++;
      if (done_q.size() != 1 || done_q[0] != t0 + NS + 3) begin
        errors++;
        $display("FAIL %s done_cycle: got %0d pulses, first at rel %0d, expected 1 pulse at rel %0d",
                 tag, done_q.size(), (done_q.size() > 0) ? done_q[0] - t0 : -1, NS + 3);
      end
      checks++;
      if (busy_q.size() != NS + 2 || busy_q[0] != t0 + 1 || busy_q[busy_q.size()-1] != t0 + NS + 2) begin
        errors++;
        $display("FAIL %s busy_window: got %0d cycles, expected %0d cycles rel 1..%0d",
                 tag, busy_q.size(), NS + 2, NS + 2);
      end
      checks++;
      if (rd_q.size() != NS + 1) begin
        errors++;
        $display("FAIL %s read_count: got %0d expected %0d", tag, rd_q.size(), NS + 1);
      end
      n = (rd_q.size() < NS + 1) ? rd_q.size() : NS + 1;
      for (int i = 0; i < n; i++) begin
        checks++;
        if (rd_q[i].addr != ((i == 0) ? NS - 1 : i - 1) || rd_q[i].cyc != t0 + 1 + i) begin
          errors++;
          $display("FAIL %s rd[%0d]: got addr %0d at rel %0d, expected addr %0d at rel %0d",
                   tag, i, rd_q[i].addr, rd_q[i].cyc - t0, (i == 0) ? NS - 1 : i - 1, 1 + i);
        end
      end
      checks++;
      if (wr_q.size() != NS) begin
        errors++;
        $display("FAIL %s write_count: got %0d expected %0d", tag, wr_q.size(), NS);
      end
      n = (wr_q.size() < NS) ? wr_q.size() : NS;
      for (int i = 0; i < n; i++) begin
        checks++;
        if (wr_q[i].addr != i || wr_q[i].cyc != t0 + 3 + i || wr_q[i].data !== exp_st[i]) begin
          errors++;
          $display("FAIL %s wr[%0d]: got addr %0d data %h at rel %0d, expected addr %0d data %h at rel %0d",
                   tag, i, wr_q[i].addr, wr_q[i].data, wr_q[i].cyc - t0, i, exp_st[i], 3 + i);
        end
      end
      order_ok = 1'b1;
      foreach (rd_q[r])
        foreach (wr_q[w])
          if (wr_q[w].addr == rd_q[r].addr && wr_q[w].cyc <= rd_q[r].cyc) order_ok = 1'b0;
      checks++;
      if (!order_ok) begin
        errors++;
        $display("FAIL %s read_after_write: got a read of an already-written address, expected none", tag);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, rd_en, wr_en} !== 4'b0 || rd_addr !== '0 || wr_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b rd_en=%b wr_en=%b rd_addr=%0d wr_addr=%0d, expected all 0",
               busy, done, rd_en, wr_en, rd_addr, wr_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0 || busy_q.size() != 0) begin
      errors++;
      $display("FAIL reset_idle_access: got %0d reads %0d writes %0d busy cycles, expected 0",
               rd_q.size(), wr_q.size(), busy_q.size());
    end
  endtask

  task automatic test_all_zero();
    int t0;
    load_state(0);
    do_pass(-1, -1, t0);
    check_pass(t0, "zero");
  endtask

  task automatic test_wrap();
    int t0;
    load_state(1);
    do_pass(-1, -1, t0);
    check_pass(t0, "wrap");
    if (wr_q.size() == NS) begin
      checks++;
      if (wr_q[0].data !== 25'h1084210 || wr_q[NS-1].data !== 25'h0210843) begin
        errors++;
        $display("FAIL wrap_const: got slice0 %h slice63 %h, expected 1084210 0210843",
                 wr_q[0].data, wr_q[NS-1].data);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0a, t0b;
    load_state(2);
    do_pass(-1, -1, t0a);
    check_pass(t0a, "b2b_first");
    do_pass(-1, -1, t0b);
    checks++;
    if (t0b != t0a + NS + 4) begin
      errors++;
      $display("FAIL b2b_start: got second start at rel %0d, expected %0d", t0b - t0a, NS + 4);
    end
    check_pass(t0b, "b2b_second");
  endtask

  task automatic test_start_ignored();
    int t0;
    load_state(2);
    do_pass(10, 40, t0);
    check_pass(t0, "start_busy");
  endtask

  task automatic test_mid_reset();
    int t0;
    load_state(2);
    @(negedge clk);
    t0 = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc - t0 < 30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, rd_en, wr_en} !== 4'b0 || rd_addr !== '0 || wr_addr !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b done=%b rd_en=%b wr_en=%b rd_addr=%0d wr_addr=%0d, expected all 0",
               busy, done, rd_en, wr_en, rd_addr, wr_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_quiet: got %0d writes %0d reads %0d done, expected 0",
               wr_q.size(), rd_q.size(), done_q.size());
    end
    do_pass(-1, -1, t0);
    check_pass(t0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_wrap();
    test_back_to_back();
    test_start_ignored();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
